block_mean_accum: RTL and testbench
===================================

BLOCK_MEAN_ACCUM -- requirements
Module: block_mean_accum

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, the divider operand width; the valid range is SIZE >= 16.
REQ-002 The block SHALL have parameter ROUND, default 0; 0 selects truncating mean, 1 selects round-half-up mean.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: the input sample is valid.
REQ-006 The block SHALL have port s_data, input, 8 bits: the pixel sample.
REQ-007 The block SHALL have port s_last, input, 1 bit: marks the final sample of a block.
REQ-008 The block SHALL have port s_ready, output, 1 bit: the block accepts a sample.
REQ-009 The block SHALL have port div_a, output, SIZE bits: the dividend driven to the external combinational divider.
REQ-010 The block SHALL have port div_b, output, SIZE bits: the divisor driven to the external combinational divider.
REQ-011 The block SHALL have port div_q, input, SIZE bits: the quotient returned by the divider.
REQ-012 The block SHALL have port div_r, input, SIZE bits: the remainder returned by the divider.
REQ-013 The block SHALL have port m_valid, output, 1 bit: the result is valid.
REQ-014 The block SHALL have port m_ready, input, 1 bit: the downstream stage accepts the result.
REQ-015 The block SHALL have port m_mean, output, 8 bits: the block mean, equal to div_q[7:0].
REQ-016 The block SHALL have port m_rem, output, SIZE bits: the remainder, equal to div_r.
REQ-017 The block SHALL have port m_count, output, 8 bits: the number of samples in the block.

Function
REQ-018 The block SHALL implement a 3-state FSM with states ACCUM, DIVIDE and OUTPUT, a SIZE-bit sum register and an 8-bit cnt register.
REQ-019 In ACCUM, s_ready SHALL be 1; in DIVIDE and OUTPUT, s_ready SHALL be 0.
REQ-020 A sample SHALL be accepted when s_valid and s_ready are both 1; on acceptance, sum <= sum + s_data and cnt <= cnt + 1.
REQ-021 On an accepted sample with s_last=1, or on an accepted sample that makes cnt reach 255, the FSM SHALL go ACCUM->DIVIDE; forced termination at cnt 255 means sum never exceeds 65025.
REQ-022 In all states, div_a SHALL be sum when ROUND=0, and sum + (cnt>>1) when ROUND=1.
REQ-023 In all states, div_b SHALL be zero-extended cnt, so it is stable throughout DIVIDE.
REQ-024 In DIVIDE, div_b SHALL never be 0, because at least one sample has been accepted.
REQ-025 DIVIDE SHALL last exactly 1 cycle, during which m_mean <= div_q[7:0], m_rem <= div_r, m_count <= cnt; the FSM SHALL then go to OUTPUT.
REQ-026 In OUTPUT, m_valid SHALL be 1 and m_mean, m_rem and m_count SHALL hold constant until m_ready=1.
REQ-027 On the OUTPUT cycle where m_ready=1, the block SHALL set sum <= 0 and cnt <= 0 and go to ACCUM, with s_ready=1 on the next cycle.
REQ-028 Latency: if the s_last beat is accepted at edge t, m_valid SHALL rise after edge t+1 and be sampled high at edge t+2.
REQ-029 Throughput: with m_ready held 1, an N-sample block SHALL occupy N+2 cycles.
REQ-030 s_valid SHALL be ignored while s_ready=0; no sample is lost or double-counted, and the upstream stage holds its data.
REQ-031 m_ready=1 while m_valid=0 SHALL have no effect.
REQ-032 Results SHALL not be corrupted by back-pressure: m_valid stays high under m_ready=0 for any number of cycles.
REQ-033 If s_valid=1 with s_last=0 arrives at cnt=254, the block SHALL accept it and terminate the block at cnt=255 as if s_last were 1.

Reset
REQ-034 When rst_n=0, the block SHALL asynchronously force state=ACCUM, sum=0, cnt=0, m_valid=0, m_mean=0, m_rem=0, m_count=0; this gives div_a=0, div_b=0 and s_ready=1.
REQ-035 When rst_n is asserted during DIVIDE or OUTPUT, the block SHALL discard the pending result with no m_valid pulse after reset.
REQ-036 rst_n deassertion SHALL take effect on the first rising edge of clk after release; s_ready SHALL be 1 from that edge.

Verification
REQ-037 A bench SHALL drive samples 10, 20, 31 with s_last on 31 and m_ready=1, ROUND=0, and SHALL require m_mean=20, m_rem=1, m_count=3, with m_valid sampled high 2 cycles after the last beat.
REQ-038 A bench SHALL repeat the REQ-037 sequence with ROUND=1, requiring div_a=62 and m_mean=20; it SHALL also drive samples 1 and 2 (last), requiring m_mean=2 (ROUND=1) and m_mean=1 (ROUND=0).
REQ-039 A bench SHALL drive 255 samples of 255 with no s_last, requiring forced termination, div_a=65025, div_b=255, m_mean=255, m_rem=0, m_count=255.
REQ-040 A bench SHALL drive a single sample 7 with s_last, then hold m_ready=0 for 5 cycles and keep s_valid high, requiring m_valid=1 held, m_mean=7, m_count=1, s_ready=0 throughout, and no extra sample counted.
REQ-041 A bench SHALL assert rst_n=0 during OUTPUT, requiring all outputs to reach reset values without waiting for a clock edge; after release, a 2-sample block of 4 and 6 SHALL give m_mean=5.
REQ-042 A bench SHALL drive back-to-back blocks {100} and {50, 60}, with random s_valid gaps and random m_ready, requiring results 100/1 then 55/2 in order and sum cleared between blocks.

Source files
------------

// File: rtl/block_mean_accum.sv
`default_nettype none
// =============================================================================
// Module   : block_mean_accum
// Brief    : Accumulates 8-bit samples per block and emits the block mean using
//            an external combinational divider (truncating or round-half-up).
// Revision : 1.0
// =============================================================================
module block_mean_accum #(
  parameter int SIZE  = 16,
  parameter int ROUND = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  input  logic [7:0]      s_data,
  input  logic            s_last,
  output logic            s_ready,
  output logic [SIZE-1:0] div_a,
  output logic [SIZE-1:0] div_b,
  input  logic [SIZE-1:0] div_q,
  input  logic [SIZE-1:0] div_r,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [7:0]      m_mean,
  output logic [SIZE-1:0] m_rem,
  output logic [7:0]      m_count
);

  localparam logic [1:0] S_ACCUM  = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  logic [1:0]      r_state;
  logic [SIZE-1:0] r_sum;
  logic [7:0]      r_cnt;
  logic [7:0]      r_mean;
  logic [SIZE-1:0] r_rem;
  logic [7:0]      r_count;

  logic            w_accept;
  logic            w_block_end;
  logic [SIZE-1:0] w_cnt_ext;
  logic [SIZE-1:0] w_data_ext;
  logic            w_unused_q;

  assign s_ready     = (r_state == S_ACCUM);
  assign w_accept    = s_valid & s_ready;
  // A block is force-closed on its 255th sample so the sum stays within 16 bits.
  assign w_block_end = s_last | (r_cnt == 8'd254);
  assign w_cnt_ext   = {{(SIZE-8){1'b0}}, r_cnt};
  assign w_data_ext  = {{(SIZE-8){1'b0}}, s_data};
  assign w_unused_q  = ^div_q[SIZE-1:8];

  assign div_b   = w_cnt_ext;
  assign m_valid = (r_state == S_OUTPUT);
  assign m_mean  = r_mean;
  assign m_rem   = r_rem;
  assign m_count = r_count;

  generate
    if (ROUND != 0) begin : g_round
      assign div_a = r_sum + (w_cnt_ext >> 1);
    end else begin : g_trunc
      assign div_a = r_sum;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_mean  <= '0;
      r_rem   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (w_accept) begin
            r_sum <= r_sum + w_data_ext;
            r_cnt <= r_cnt + 8'd1;
            if (w_block_end) begin
              r_state <= S_DIVIDE;
            end
          end
        end
        S_DIVIDE: begin
          r_mean  <= div_q[7:0];
          r_rem   <= div_r;
          r_count <= r_cnt;
          r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (m_ready) begin
            r_sum   <= '0;
            r_cnt   <= '0;
            r_state <= S_ACCUM;
          end
        end
        default: begin
          r_state <= S_ACCUM;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_mean_accum.sv
`default_nettype none
// =============================================================================
// Module   : tb_block_mean_accum
// Brief    : Self-checking bench driving truncating and rounding instances side
//            by side against an arithmetic mean model.
// Revision : 1.0
// =============================================================================
module tb_block_mean_accum;

  localparam int SIZE = 16;

  logic            clk;
  logic            rst_n;
  logic            s_valid;
  logic [7:0]      s_data;
  logic            s_last;
  logic            m_ready;

  logic            t_ready, t_valid;
  logic [SIZE-1:0] t_div_a, t_div_b, t_div_q, t_div_r, t_rem;
  logic [7:0]      t_mean, t_count;

  logic            r_ready, r_valid;
  logic [SIZE-1:0] r_div_a, r_div_b, r_div_q, r_div_r, r_rem;
  logic [7:0]      r_mean, r_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Ideal external dividers
  assign t_div_q = (t_div_b != 0) ? t_div_a / t_div_b : '0;
  assign t_div_r = (t_div_b != 0) ? t_div_a % t_div_b : '0;
  assign r_div_q = (r_div_b != 0) ? r_div_a / r_div_b : '0;
  assign r_div_r = (r_div_b != 0) ? r_div_a % r_div_b : '0;

  block_mean_accum #(.SIZE(SIZE), .ROUND(0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(t_ready), .div_a(t_div_a), .div_b(t_div_b), .div_q(t_div_q), .div_r(t_div_r),
    .m_valid(t_valid), .m_ready(m_ready), .m_mean(t_mean), .m_rem(t_rem), .m_count(t_count)
  );

  block_mean_accum #(.SIZE(SIZE), .ROUND(1)) u_round (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(r_ready), .div_a(r_div_a), .div_b(r_div_b), .div_q(r_div_q), .div_r(r_div_r),
    .m_valid(r_valid), .m_ready(m_ready), .m_mean(r_mean), .m_rem(r_rem), .m_count(r_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mean of a block from plain arithmetic; rounding adds half the count first.
  function automatic void model(input int d[$], input bit rnd,
                                output int a, output int b, output int q, output int r);
    int s;
    s = 0;
    foreach (d[i]) s += d[i];
    b = d.size();
    a = rnd ? s + b / 2 : s;
    q = a / b;
    r = a % b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " trunc m_valid"}, t_valid, 0);
    chk({tag, " round m_valid"}, r_valid, 0);
    chk({tag, " trunc s_ready"}, t_ready, 1);
    chk({tag, " round s_ready"}, r_ready, 1);
    chk({tag, " trunc div_a"}, t_div_a, 0);
    chk({tag, " round div_a"}, r_div_a, 0);
    chk({tag, " div_b"}, t_div_b, 0);
  endtask

  task automatic check_divide(input int d[$], input string tag);
    int a, b, q, r;
    model(d, 1'b0, a, b, q, r);
    chk({tag, " divide trunc m_valid"}, t_valid, 0);
    chk({tag, " divide trunc s_ready"}, t_ready, 0);
    chk({tag, " divide trunc div_a"}, t_div_a, a);
    chk({tag, " divide trunc div_b"}, t_div_b, b);
    model(d, 1'b1, a, b, q, r);
    chk({tag, " divide round s_ready"}, r_ready, 0);
    chk({tag, " divide round div_a"}, r_div_a, a);
    chk({tag, " divide round div_b"}, r_div_b, b);
  endtask

  task automatic check_out(input int d[$], input string tag);
    int a, b, q, r;
    model(d, 1'b0, a, b, q, r);
    chk({tag, " trunc m_valid"}, t_valid, 1);
    chk({tag, " trunc s_ready"}, t_ready, 0);
    chk({tag, " trunc m_mean"}, t_mean, q & 255);
    chk({tag, " trunc m_rem"}, t_rem, r);
    chk({tag, " trunc m_count"}, t_count, b);
    model(d, 1'b1, a, b, q, r);
    chk({tag, " round m_valid"}, r_valid, 1);
    chk({tag, " round s_ready"}, r_ready, 0);
    chk({tag, " round m_mean"}, r_mean, q & 255);
    chk({tag, " round m_rem"}, r_rem, r);
    chk({tag, " round m_count"}, r_count, b);
  endtask

  // Leaves the bench one step after the final sample is accepted (DIVIDE).
  task automatic send(input int d[$], input bit use_last, input int max_gap, input bit rnd_mready);
    for (int i = 0; i < d.size(); i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        if (rnd_mready) m_ready = 1'($urandom);
        step();
      end
      s_valid = 1'b1;
      s_data  = 8'(d[i]);
      s_last  = use_last && (i == d.size() - 1);
      if (rnd_mready) m_ready = 1'($urandom);
      if (i == 0) chk("send s_ready", t_ready, 1);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_block(input int d[$], input string tag, input int hold, input bit sval_hold);
    check_divide(d, tag);
    m_ready = 1'b0;
    step();
    check_out(d, tag);
    for (int k = 0; k < hold; k++) begin
      s_valid = sval_hold;
      s_data  = 8'($urandom);
      s_last  = 1'($urandom);
      step();
      check_out(d, {tag, " hold"});
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check_idle({tag, " after"});
  endtask

  task automatic run_block(input int d[$], input bit use_last, input string tag,
                           input int max_gap, input int hold, input bit sval_hold, input bit rnd_mready);
    send(d, use_last, max_gap, rnd_mready);
    finish_block(d, tag, hold, sval_hold);
  endtask

  initial begin
    int q[$];
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_idle("reset");
    chk("reset trunc m_mean", t_mean, 0);
    chk("reset trunc m_count", t_count, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // 10,20,31: truncated 20 rem 1, rounded dividend 62
    q = {10, 20, 31};
    send(q, 1'b1, 0, 1'b0);
    chk("b1 round div_a literal", r_div_a, 62);
    finish_block(q, "b1", 0, 1'b0);
    chk("b1 trunc m_mean literal", t_mean, 20);
    chk("b1 trunc m_rem literal", t_rem, 1);

    q = {1, 2};
    run_block(q, 1'b1, "b2", 0, 0, 1'b0, 1'b0);
    chk("b2 round m_mean literal", r_mean, 2);
    chk("b2 trunc m_mean literal", t_mean, 1);

    // Forced termination after 255 full-scale samples
    q.delete();
    for (int i = 0; i < 255; i++) q.push_back(255);
    send(q, 1'b0, 0, 1'b0);
    chk("b255 trunc div_a literal", t_div_a, 65025);
    chk("b255 trunc div_b literal", t_div_b, 255);
    finish_block(q, "b255", 1, 1'b0);

    // Back-pressure while upstream keeps offering data
    q = {7};
    run_block(q, 1'b1, "bp", 0, 5, 1'b1, 1'b0);

    // Reset while OUTPUT is pending
    q = {9, 11};
    send(q, 1'b1, 0, 1'b0);
    step();
    chk("rst_out m_valid before", t_valid, 1);
    rst_n = 1'b0;
    #2;
    check_idle("rst_out");
    chk("rst_out trunc m_mean", t_mean, 0);
    chk("rst_out round m_rem", r_rem, 0);
    chk("rst_out round m_count", r_count, 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("rst_out post");
    end
    q = {4, 6};
    run_block(q, 1'b1, "rst_out next", 0, 0, 1'b0, 1'b0);

    // Reset during DIVIDE discards the result
    q = {200, 3};
    send(q, 1'b1, 0, 1'b0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_idle("rst_div post");
    end

    // Back-to-back blocks with random gaps and random m_ready
    q = {100};
    run_block(q, 1'b1, "bb1", 3, int'($urandom_range(3, 0)), 1'b1, 1'b1);
    q = {50, 60};
    run_block(q, 1'b1, "bb2", 3, int'($urandom_range(3, 0)), 1'b1, 1'b1);

    // Random blocks
    for (int n = 0; n < 8; n++) begin
      int len;
      len = int'($urandom_range(12, 1));
      q.delete();
      for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(255, 0)));
      run_block(q, 1'b1, "rand", 2, int'($urandom_range(3, 0)), 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
